tenmhz_clock_recovery: RTL and testbench
========================================

Name: tenmhz_clock_recovery

Overview:
Receive-side counterpart of the 10 MHz link clock generator. Samples an incoming 10 MHz clock (2-high/3-low at 50 MHz) from the partner DE2 board in the local 50 MHz domain. Produces one local-domain strobe per incoming rising edge, measures the incoming period, and reports lock and loss-of-clock. Downstream DDS link logic uses edge_strobe as its word-timing enable and gates transfers on locked.

Parameters:
NOMINAL_PERIOD, 5, expected incoming period in 50 MHz cycles
TOLERANCE, 1, accepted deviation: period in [NOMINAL_PERIOD-TOLERANCE, NOMINAL_PERIOD+TOLERANCE]
LOCK_COUNT, 8, consecutive good periods required to declare lock
TIMEOUT, 16, cycles without a rising edge before the clock is declared lost
CNT_W, 5, width of the period counter and period_out; must satisfy 2^CNT_W-1 > TIMEOUT

Ports:
FiftyMHz_ref_clock  input  1  local 50 MHz clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
TenMHz_in  input  1  incoming 10 MHz clock, asynchronous to local clock
clear_loss  input  1  synchronous clear of the sticky loss_of_clock flag
edge_strobe  output  1  one-cycle pulse per detected incoming rising edge
period_out  output  CNT_W  last measured period in local cycles
locked  output  1  high while in LOCKED state
loss_of_clock  output  1  sticky; set on timeout from LOCKED
good_cnt  output  4  current consecutive-good-period count (debug)

Behaviour:
- Reset (async, active-high): sync flops, prev flop, counters, all outputs to 0; state SEARCH.
- Input path: 2-flop synchronizer (s1, s2), then prev <= s2. rise = s2 & ~prev.
- Latency: edge_strobe is registered and high on the 3rd local clock edge after the edge at which s1 first captures 1; exactly one cycle wide.
- Period counter cnt: on rise, cnt <= 1; otherwise cnt <= cnt+1, saturating at 2^CNT_W-1. On rise, period_out <= cnt (cycles between consecutive rises; 5 nominal). On the first rise after SEARCH, period_out is not updated.
- good(p) = p >= NOMINAL_PERIOD-TOLERANCE and p <= NOMINAL_PERIOD+TOLERANCE.
- State machine:
  SEARCH: on rise -> ACQUIRE, good_cnt <= 0, cnt <= 1.
  ACQUIRE: on rise, if good(cnt) then good_cnt++; when good_cnt reaches LOCK_COUNT -> LOCKED. If not good, good_cnt <= 0 and stay. If cnt > TIMEOUT -> SEARCH.
  LOCKED: locked=1. A single bad period sets bad flag; two consecutive bad periods -> ACQUIRE, good_cnt <= 0. A good period clears bad flag. If cnt > TIMEOUT -> LOST, loss_of_clock <= 1.
  LOST: locked=0; on rise -> ACQUIRE, good_cnt <= 0.
- locked drops in the same cycle the state leaves LOCKED (registered with state).
- loss_of_clock: set only on the LOCKED->LOST transition; cleared by clear_loss. If set and clear occur in the same cycle, set wins.
- edge_strobe fires for every rise in every state, including SEARCH and LOST.
- Reset mid-operation: immediate return to reset values. A TenMHz_in held high through reset release produces one rise and one edge_strobe, which is the SEARCH->ACQUIRE trigger.
- good_cnt saturates at LOCK_COUNT.

Decomposition:
- Shared package: state encoding (SEARCH, ACQUIRE, LOCKED, LOST) and default constants NOMINAL_PERIOD=5, TOLERANCE=1, LOCK_COUNT=8, TIMEOUT=16.
- One sub-module: edge_sync_detect (2-flop synchronizer plus rise detector, outputs rise). Counter and FSM stay in the top.

Test Plan:
- Nominal 10 MHz (2 high/3 low, phase-aligned): first edge_strobe 3 cycles after first high sample; period_out=5; locked rises on the 9th rise (1 start + 8 good).
- Locked, then one 7-cycle period: locked stays 1, period_out=7. Two consecutive 7-cycle periods: locked drops after the second, state ACQUIRE, good_cnt=0.
- Locked, then TenMHz_in held low: locked falls and loss_of_clock sets when cnt reaches 17. Pulse clear_loss: flag clears. Resume clock: relock after 8 good periods.
- 6- and 4-cycle periods alternating (within tolerance): lock achieved. 3-cycle periods: never locks, good_cnt stays 0.
- Assert reset while locked: all outputs 0 next sample. Release with TenMHz_in high: exactly one edge_strobe, state ACQUIRE.
- Asynchronous jitter (input phase swept across local clock): exactly one edge_strobe per input rise, period_out always within 4..6.

Source files
------------

// File: rtl/tenmhz_clock_recovery_pkg.sv
// Shared types and default constants for the 10 MHz link clock recovery block.
// The state encoding and the period window check are also used by the top-level FSM.
package tenmhz_clock_recovery_pkg;

   typedef enum logic [1:0] {
      StSearch  = 2'd0,
      StAcquire = 2'd1,
      StLocked  = 2'd2,
      StLost    = 2'd3
   } recoveryState_t;

   localparam int unsigned DefNominalPeriod = 5;
   localparam int unsigned DefTolerance     = 1;
   localparam int unsigned DefLockCount     = 8;
   localparam int unsigned DefTimeout       = 16;

   // Rewritten as period+tol >= nominal so the lower bound cannot underflow.
   function automatic logic isGood(input int unsigned period,
                                   input int unsigned nominal,
                                   input int unsigned tol);
      return ((period + tol) >= nominal) && (period <= (nominal + tol));
   endfunction

endpackage

// File: rtl/tenmhz_clock_recovery_edge_sync_detect.sv
// Two-flop synchronizer for the partner board's 10 MHz clock, followed by a registered
// rising-edge detector. The output rise is a one-cycle pulse in the local domain.
module tenmhz_clock_recovery_edge_sync_detect
   import tenmhz_clock_recovery_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic asyncIn,
   output logic rise
);

   logic syncS1Q;
   logic syncS2Q;
   logic prevQ;
   logic riseQ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncS1Q <= 1'b0;
         syncS2Q <= 1'b0;
         prevQ   <= 1'b0;
         riseQ   <= 1'b0;
      end else begin
         syncS1Q <= asyncIn;
         syncS2Q <= syncS1Q;
         prevQ   <= syncS2Q;
         riseQ   <= syncS2Q & ~prevQ;
      end
   end

   assign rise = riseQ;

endmodule

// File: rtl/tenmhz_clock_recovery.sv
// Recovers the partner board's 10 MHz link clock: edge strobes, period measurement,
// lock tracking and a sticky loss-of-clock flag for the downstream DDS link logic.
module tenmhz_clock_recovery
   import tenmhz_clock_recovery_pkg::*;
#(
   parameter int unsigned NOMINAL_PERIOD = DefNominalPeriod,
   parameter int unsigned TOLERANCE      = DefTolerance,
   parameter int unsigned LOCK_COUNT     = DefLockCount,
   parameter int unsigned TIMEOUT        = DefTimeout,
   parameter int unsigned CNT_W          = 5
) (
   input  logic             FiftyMHz_ref_clock,
   input  logic             reset,
   input  logic             TenMHz_in,
   input  logic             clear_loss,
   output logic             edge_strobe,
   output logic [CNT_W-1:0] period_out,
   output logic             locked,
   output logic             loss_of_clock,
   output logic [3:0]       good_cnt
);

   localparam logic [CNT_W-1:0] CntMax     = '1;
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
   localparam logic [3:0]       LockCnt    = 4'(LOCK_COUNT);

   logic rise;

   recoveryState_t   stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic [CNT_W-1:0] periodQ, periodD;
   logic [3:0]       goodQ, goodD;
   logic [3:0]       goodInc;
   logic             badQ, badD;
   logic             lossQ, lossD;
   logic             strobeQ;
   logic             periodGood;
   logic             timedOut;

   tenmhz_clock_recovery_edge_sync_detect uEdgeSync (
      .clk     (FiftyMHz_ref_clock),
      .reset   (reset),
      .asyncIn (TenMHz_in),
      .rise    (rise)
   );

   // cnt holds the cycles since the previous rise, i.e. the period being closed by this rise.
   assign periodGood = isGood(32'(cntQ), NOMINAL_PERIOD, TOLERANCE);
   assign timedOut   = (cntQ > TimeoutCnt);
   assign goodInc    = (goodQ < LockCnt) ? (goodQ + 4'd1) : goodQ;

   always_comb begin
      stateD  = stateQ;
      cntD    = cntQ;
      periodD = periodQ;
      goodD   = goodQ;
      badD    = badQ;
      lossD   = lossQ;

      if (rise) begin
         cntD = CntOne;
      end else if (cntQ != CntMax) begin
         cntD = cntQ + 1'b1;
      end

      // The first rise out of SEARCH has no previous edge to measure against.
      if (rise && (stateQ != StSearch)) begin
         periodD = cntQ;
      end

      if (clear_loss) begin
         lossD = 1'b0;
      end

      unique case (stateQ)
         StSearch: begin
            if (rise) begin
               stateD = StAcquire;
               goodD  = '0;
            end
         end

         StAcquire: begin
            if (rise) begin
               if (periodGood) begin
                  goodD = goodInc;
                  if (goodInc == LockCnt) begin
                     stateD = StLocked;
                     badD   = 1'b0;
                  end
               end else begin
                  goodD = '0;
               end
            end else if (timedOut) begin
               stateD = StSearch;
            end
         end

         StLocked: begin
            if (rise) begin
               if (periodGood) begin
                  badD  = 1'b0;
                  goodD = goodInc;
               end else if (badQ) begin
                  stateD = StAcquire;
                  goodD  = '0;
                  badD   = 1'b0;
               end else begin
                  badD = 1'b1;
               end
            end else if (timedOut) begin
               // Set overrides a simultaneous clear_loss.
               stateD = StLost;
               lossD  = 1'b1;
               badD   = 1'b0;
            end
         end

         StLost: begin
            if (rise) begin
               stateD = StAcquire;
               goodD  = '0;
            end
         end

         default: begin
            stateD = StSearch;
         end
      endcase
   end

   always_ff @(posedge FiftyMHz_ref_clock or posedge reset) begin
      if (reset) begin
         stateQ  <= StSearch;
         cntQ    <= '0;
         periodQ <= '0;
         goodQ   <= '0;
         badQ    <= 1'b0;
         lossQ   <= 1'b0;
         strobeQ <= 1'b0;
      end else begin
         stateQ  <= stateD;
         cntQ    <= cntD;
         periodQ <= periodD;
         goodQ   <= goodD;
         badQ    <= badD;
         lossQ   <= lossD;
         strobeQ <= rise;
      end
   end

   assign edge_strobe   = strobeQ;
   assign period_out    = periodQ;
   assign locked        = (stateQ == StLocked);
   assign loss_of_clock = lossQ;
   assign good_cnt      = goodQ;

endmodule

// File: tb/tb_tenmhz_clock_recovery.sv
// Directed bench for tenmhz_clock_recovery: a table of steady input patterns plus
// hand-written sequences for latency, bad periods, loss of clock, reset and phase drift.
module tb_tenmhz_clock_recovery;

   localparam int unsigned CntW = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            tenIn;
   logic            clearLoss;
   logic            edgeStrobe;
   logic [CntW-1:0] periodOut;
   logic            lockedOut;
   logic            lossOut;
   logic [3:0]      goodCnt;

   int nChecks = 0;
   int nPass   = 0;
   int nRise   = 0;
   int nStrobe = 0;
   int nBad    = 0;

   typedef struct {
      int hi;
      int lo;
      int reps;
      int expPeriod;
      int expGood;
      int expLocked;
   } vec_t;

   vec_t vecs[6];

   tenmhz_clock_recovery #(
      .NOMINAL_PERIOD (5),
      .TOLERANCE      (1),
      .LOCK_COUNT     (8),
      .TIMEOUT        (16),
      .CNT_W          (CntW)
   ) dut (
      .FiftyMHz_ref_clock (clk),
      .reset              (reset),
      .TenMHz_in          (tenIn),
      .clear_loss         (clearLoss),
      .edge_strobe        (edgeStrobe),
      .period_out         (periodOut),
      .locked             (lockedOut),
      .loss_of_clock      (lossOut),
      .good_cnt           (goodCnt)
   );

   always #100 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      nChecks++;
      if (actual == expected) nPass++;
      else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // All stimulus changes land 1 unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      tenIn     = 1'b0;
      clearLoss = 1'b0;
      reset     = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);
   endtask

   task automatic drive(input int hi, input int lo);
      tenIn = 1'b1;
      idle(hi);
      tenIn = 1'b0;
      idle(lo);
   endtask

   task automatic driveNominal(input int n);
      for (int i = 0; i < n; i++) drive(2, 3);
   endtask

   initial begin
      int k;
      int strobes;

      vecs[0] = '{hi: 2, lo: 3, reps: 9,  expPeriod: 5, expGood: 8, expLocked: 1};
      vecs[1] = '{hi: 2, lo: 3, reps: 8,  expPeriod: 5, expGood: 7, expLocked: 0};
      vecs[2] = '{hi: 3, lo: 3, reps: 9,  expPeriod: 6, expGood: 8, expLocked: 1};
      vecs[3] = '{hi: 2, lo: 2, reps: 9,  expPeriod: 4, expGood: 8, expLocked: 1};
      vecs[4] = '{hi: 1, lo: 2, reps: 12, expPeriod: 3, expGood: 0, expLocked: 0};
      vecs[5] = '{hi: 4, lo: 3, reps: 9,  expPeriod: 7, expGood: 0, expLocked: 0};

      tenIn     = 1'b0;
      clearLoss = 1'b0;
      reset     = 1'b1;
      idle(1);
      check("reset_strobe", int'(edgeStrobe), 0);
      check("reset_period", int'(periodOut), 0);
      check("reset_locked", int'(lockedOut), 0);
      check("reset_loss", int'(lossOut), 0);
      check("reset_good", int'(goodCnt), 0);

      // Steady patterns, each from a fresh reset.
      for (int i = 0; i < 6; i++) begin
         doReset();
         for (int r = 0; r < vecs[i].reps; r++) drive(vecs[i].hi, vecs[i].lo);
         idle(4);
         check($sformatf("vec%0d_period", i), int'(periodOut), vecs[i].expPeriod);
         check($sformatf("vec%0d_good", i), int'(goodCnt), vecs[i].expGood);
         check($sformatf("vec%0d_locked", i), int'(lockedOut), vecs[i].expLocked);
      end

      // First-edge latency and strobe width.
      doReset();
      tenIn = 1'b1;
      k = 0;
      while (!edgeStrobe && k < 10) begin
         idle(1);
         k++;
      end
      check("first_strobe_latency", k, 4);
      idle(1);
      check("strobe_one_cycle", int'(edgeStrobe), 0);
      tenIn = 1'b0;

      // One 7-cycle period is tolerated, the second in a row drops lock.
      doReset();
      driveNominal(9);
      drive(4, 3);
      drive(4, 3);
      check("one_bad_locked", int'(lockedOut), 1);
      check("one_bad_period", int'(periodOut), 7);
      drive(2, 3);
      check("two_bad_locked", int'(lockedOut), 0);
      check("two_bad_good", int'(goodCnt), 0);

      // Loss of clock, clear, relock.
      doReset();
      driveNominal(9);
      check("loss_pre_locked", int'(lockedOut), 1);
      k = 0;
      while (lockedOut && k < 40) begin
         idle(1);
         k++;
      end
      check("loss_timeout_cycles", k, 16);
      check("loss_flag_set", int'(lossOut), 1);
      clearLoss = 1'b1;
      idle(1);
      clearLoss = 1'b0;
      check("loss_flag_cleared", int'(lossOut), 0);
      driveNominal(8);
      check("relock_after_8", int'(lockedOut), 0);
      driveNominal(1);
      check("relock_after_9", int'(lockedOut), 1);
      check("relock_loss_low", int'(lossOut), 0);

      // Alternating 6- and 4-cycle periods stay inside the window.
      doReset();
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0) drive(3, 3);
         else drive(2, 2);
      end
      check("alt_locked", int'(lockedOut), 1);
      check("alt_good", int'(goodCnt), 8);
      check("alt_period", int'(periodOut), 4);

      // Reset while locked, released with the input held high.
      doReset();
      driveNominal(9);
      check("prereset_locked", int'(lockedOut), 1);
      tenIn = 1'b1;
      reset = 1'b1;
      idle(1);
      check("midreset_strobe", int'(edgeStrobe), 0);
      check("midreset_period", int'(periodOut), 0);
      check("midreset_locked", int'(lockedOut), 0);
      check("midreset_loss", int'(lossOut), 0);
      check("midreset_good", int'(goodCnt), 0);
      idle(1);
      reset   = 1'b0;
      strobes = 0;
      for (int i = 0; i < 10; i++) begin
         idle(1);
         strobes += int'(edgeStrobe);
      end
      check("release_high_strobes", strobes, 1);
      check("release_high_period", int'(periodOut), 0);
      check("release_high_locked", int'(lockedOut), 0);
      tenIn = 1'b0;

      // Input period 1006 vs local 200 units: phase drifts across the local clock.
      doReset();
      nRise   = 0;
      nStrobe = 0;
      nBad    = 0;
      @(posedge clk);
      #37;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               tenIn = 1'b1;
               nRise++;
               #404;
               tenIn = 1'b0;
               #602;
            end
         end
         begin
            repeat (170) begin
               @(negedge clk);
               if (edgeStrobe) begin
                  nStrobe++;
                  if (nStrobe > 1 && (periodOut < 4 || periodOut > 6)) nBad++;
               end
            end
         end
      join
      check("jitter_strobe_count", nStrobe, nRise);
      check("jitter_period_range", nBad, 0);
      check("jitter_loss_after_stop", int'(lossOut), 1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
